// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared encodings and constants for the weight loader
package acc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CALC  = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } wl_state_e;

  localparam int KTAPS      = 9;
  localparam int LANES      = 8;
  localparam int ADDR_W_DEF = 18;
  localparam int DATA_W_DEF = 64;
  localparam int WB_AW_DEF  = 9;

endpackage

// File: rtl/wl_addr_gen.sv
// rtl/wl_addr_gen.sv - per-load base/word-count calculation and read issue counter
module wl_addr_gen #(
  parameter int ADDR_W = 18,
  parameter int WB_AW  = 9,
  parameter int LANES  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              calc_i,
  input  logic              issue_i,
  input  logic [7:0]        in_ch_i,
  input  logic [7:0]        och_i,
  input  logic [ADDR_W-1:0] base_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o,
  output logic              n_zero_o
);
  import acc_pkg::KTAPS;

  localparam int LSH = $clog2(LANES);

  logic [8:0]        ch_sum;
  logic [8:0]        groups;
  logic [WB_AW-1:0]  n_d, n_q;
  logic [WB_AW-1:0]  issue_d, issue_q;
  logic [ADDR_W-1:0] base_d, base_q;

  // groups = ceil(in_ch / LANES); one SRAM word per tap per group
  assign ch_sum   = {1'b0, in_ch_i} + 9'(LANES - 1);
  assign groups   = ch_sum >> LSH;
  assign n_d      = WB_AW'(groups * 9'(KTAPS));
  // channel regions are laid out back to back, so och selects the och-th block of N words
  assign base_d   = base_i + ADDR_W'(och_i) * ADDR_W'(n_d);
  assign n_zero_o = (n_d == '0);

  // issue counter restarts on every CALC and advances only on accepted reads
  always_comb begin
    issue_d = issue_q;
    if (calc_i) begin
      issue_d = '0;
    end else if (issue_i) begin
      issue_d = issue_q + WB_AW'(1);
    end
  end

  // hold base, word count and issue position for the duration of one load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q  <= '0;
      n_q     <= '0;
      issue_q <= '0;
    end else begin
      issue_q <= issue_d;
      if (calc_i) begin
        base_q <= base_d;
        n_q    <= n_d;
      end
    end
  end

  assign addr_o = base_q + ADDR_W'(issue_q);
  assign last_o = (issue_q == n_q - WB_AW'(1));

endmodule

// File: rtl/weight_loader.sv
// rtl/weight_loader.sv - fetches one output channel's 3x3 weights into a ping-pong buffer
module weight_loader #(
  parameter int ADDR_W = acc_pkg::ADDR_W_DEF,
  parameter int DATA_W = acc_pkg::DATA_W_DEF,
  parameter int LANES  = acc_pkg::LANES,
  parameter int WB_AW  = acc_pkg::WB_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_ch,
  input  logic [ADDR_W-1:0] weight_base,
  input  logic              weight_start,
  input  logic [7:0]        weight_och_cnt,
  output logic              weight_done,
  output logic              busy,
  output logic              start_ovf,
  output logic              sram_rd_en,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic              sram_gnt,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              wbuf_we,
  output logic              wbuf_bank,
  output logic [WB_AW-1:0]  wbuf_addr,
  output logic [DATA_W-1:0] wbuf_wdata,
  output logic              wbuf_rd_bank
);
  import acc_pkg::*;

  wl_state_e         state_d, state_q;
  logic [7:0]        och_q;
  logic              bank_q;
  logic              rd_bank_q;
  logic              ovf_q;
  logic              rvalid_q;
  logic [WB_AW-1:0]  wr_cnt_q;
  logic              rd_en;
  logic              issue;
  logic              calc;
  logic              last_issue;
  logic              n_zero;
  logic [ADDR_W-1:0] gen_addr;

  assign rd_en = (state_q == ST_READ);
  assign calc  = (state_q == ST_CALC);
  assign issue = rd_en & sram_gnt;

  wl_addr_gen #(
    .ADDR_W (ADDR_W),
    .WB_AW  (WB_AW),
    .LANES  (LANES)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .calc_i   (calc),
    .issue_i  (issue),
    .in_ch_i  (in_ch),
    .och_i    (och_q),
    .base_i   (weight_base),
    .addr_o   (gen_addr),
    .last_o   (last_issue),
    .n_zero_o (n_zero)
  );

  // load sequencing: IDLE -> CALC -> READ -> DRAIN -> DONE, skipping reads when N is zero
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (weight_start) state_d = ST_CALC;
      ST_CALC:  state_d = n_zero ? ST_DONE : ST_READ;
      ST_READ:  if (issue && last_issue) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // state, request capture, overflow flag and bank bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      och_q     <= '0;
      ovf_q     <= 1'b0;
      bank_q    <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && weight_start) begin
        och_q <= weight_och_cnt;
      end
      // DONE is still busy, so a start there is dropped too
      if (state_q != ST_IDLE && weight_start) begin
        ovf_q <= 1'b1;
      end
      if (state_q == ST_DONE) begin
        bank_q    <= ~bank_q;
        rd_bank_q <= bank_q;
      end
    end
  end

  // write path: SRAM data lands one cycle after the accepted read, in issue order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      wr_cnt_q <= '0;
    end else begin
      rvalid_q <= issue;
      if (calc) begin
        wr_cnt_q <= '0;
      end else if (rvalid_q) begin
        wr_cnt_q <= wr_cnt_q + WB_AW'(1);
      end
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign weight_done  = (state_q == ST_DONE);
  assign start_ovf    = ovf_q;
  assign sram_rd_en   = rd_en;
  assign sram_addr    = rd_en ? gen_addr : '0;
  assign wbuf_we      = rvalid_q;
  assign wbuf_bank    = bank_q;
  assign wbuf_addr    = rvalid_q ? wr_cnt_q : '0;
  assign wbuf_wdata   = rvalid_q ? sram_rdata : '0;
  assign wbuf_rd_bank = rd_bank_q;

endmodule

// File: tb/tb_weight_loader.sv
// tb/tb_weight_loader.sv - directed self-checking bench for weight_loader
module tb_weight_loader;
  localparam int ADDR_W = 18;
  localparam int DATA_W = 64;
  localparam int WB_AW  = 9;

  logic              clk;
  logic              rst_n;
  logic [7:0]        in_ch;
  logic [ADDR_W-1:0] weight_base;
  logic              weight_start;
  logic [7:0]        weight_och_cnt;
  logic              weight_done;
  logic              busy;
  logic              start_ovf;
  logic              sram_rd_en;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_gnt;
  logic [DATA_W-1:0] sram_rdata;
  logic              wbuf_we;
  logic              wbuf_bank;
  logic [WB_AW-1:0]  wbuf_addr;
  logic [DATA_W-1:0] wbuf_wdata;
  logic              wbuf_rd_bank;

  weight_loader #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LANES  (8),
    .WB_AW  (WB_AW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_ch          (in_ch),
    .weight_base    (weight_base),
    .weight_start   (weight_start),
    .weight_och_cnt (weight_och_cnt),
    .weight_done    (weight_done),
    .busy           (busy),
    .start_ovf      (start_ovf),
    .sram_rd_en     (sram_rd_en),
    .sram_addr      (sram_addr),
    .sram_gnt       (sram_gnt),
    .sram_rdata     (sram_rdata),
    .wbuf_we        (wbuf_we),
    .wbuf_bank      (wbuf_bank),
    .wbuf_addr      (wbuf_addr),
    .wbuf_wdata     (wbuf_wdata),
    .wbuf_rd_bank   (wbuf_rd_bank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] pat(input logic [ADDR_W-1:0] a);
    return 64'hDEAD_0000_0000_0000 | 64'(a);
  endfunction

  // SRAM model: data returns one cycle after an accepted read
  always @(posedge clk) begin
    if (sram_rd_en && sram_gnt) sram_rdata <= pat(sram_addr);
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [ADDR_W-1:0] rd_addr[$];
  int                rd_cyc[$];
  logic [WB_AW-1:0]  wr_addr[$];
  logic              wr_bank[$];
  logic [63:0]       wr_data[$];
  int                wr_cyc[$];
  int                done_cnt = 0;
  int                done_cyc = 0;
  int                hold_cnt = 0;
  int                hold_bad = 0;
  logic              prev_wait = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;

  always @(negedge clk) begin
    if (sram_rd_en && sram_gnt) begin
      rd_addr.push_back(sram_addr);
      rd_cyc.push_back(cyc);
    end
    if (wbuf_we) begin
      wr_addr.push_back(wbuf_addr);
      wr_bank.push_back(wbuf_bank);
      wr_data.push_back(wbuf_wdata);
      wr_cyc.push_back(cyc);
    end
    if (weight_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (sram_rd_en && prev_wait) begin
      hold_cnt++;
      if (sram_addr !== prev_addr) hold_bad++;
    end
    prev_wait = sram_rd_en && !sram_gnt;
    prev_addr = sram_addr;
  end

  logic gnt_mode;
  int   t0, r0, w0, d0, h0, hb0;

  task automatic step();
    @(posedge clk);
    #2;
    if (gnt_mode) sram_gnt = ~sram_gnt;
  endtask

  task automatic snap();
    r0  = rd_addr.size();
    w0  = wr_addr.size();
    d0  = done_cnt;
    h0  = hold_cnt;
    hb0 = hold_bad;
  endtask

  task automatic do_start(input logic [7:0] och);
    weight_och_cnt = och;
    weight_start   = 1'b1;
    t0             = cyc;
    step();
    weight_start   = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      step();
      n++;
    end
    if (done_cnt == d0) check("done_timeout", 64'(0), 64'(1));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic check_load(input string nm, input logic [ADDR_W-1:0] b, input int n,
                            input logic bk);
    check({nm, "_rd_count"}, 64'(rd_addr.size() - r0), 64'(n));
    check({nm, "_wr_count"}, 64'(wr_addr.size() - w0), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (r0 + i < rd_addr.size())
        check($sformatf("%s_rd_addr%0d", nm, i), 64'(rd_addr[r0+i]), 64'(b + ADDR_W'(i)));
      if (w0 + i < wr_addr.size()) begin
        check($sformatf("%s_wr_addr%0d", nm, i), 64'(wr_addr[w0+i]), 64'(i));
        check($sformatf("%s_wr_bank%0d", nm, i), 64'(wr_bank[w0+i]), 64'(bk));
        check($sformatf("%s_wr_data%0d", nm, i), wr_data[w0+i], pat(b + ADDR_W'(i)));
      end
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    in_ch          = 8'd0;
    weight_base    = '0;
    weight_start   = 1'b0;
    weight_och_cnt = 8'd0;
    sram_gnt       = 1'b1;
    gnt_mode       = 1'b0;
    step();
    step();

    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(weight_done), 64'(0));
    check("rst_ovf", 64'(start_ovf), 64'(0));
    check("rst_rd_en", 64'(sram_rd_en), 64'(0));
    check("rst_we", 64'(wbuf_we), 64'(0));
    check("rst_rd_bank", 64'(wbuf_rd_bank), 64'(0));
    check("rst_bank", 64'(wbuf_bank), 64'(0));
    rst_n = 1'b1;
    step();

    // in_ch=16, och=2, base 0x100: N=18, base 0x124
    in_ch       = 8'd16;
    weight_base = 18'h100;
    snap();
    do_start(8'd2);
    check("t1_busy", 64'(busy), 64'(1));
    wait_done(100);
    check_load("t1", 18'h124, 18, 1'b0);
    if (rd_cyc.size() >= r0 + 18) begin
      check("t1_rd_first_cyc", 64'(rd_cyc[r0]), 64'(t0 + 2));
      check("t1_rd_last_cyc", 64'(rd_cyc[r0+17]), 64'(t0 + 19));
    end
    if (wr_cyc.size() >= w0 + 18) begin
      check("t1_wr_first_cyc", 64'(wr_cyc[w0]), 64'(t0 + 3));
      check("t1_wr_last_cyc", 64'(wr_cyc[w0+17]), 64'(t0 + 20));
    end
    check("t1_done_cyc", 64'(done_cyc), 64'(t0 + 21));
    check("t1_done_cnt", 64'(done_cnt - d0), 64'(1));
    check("t1_rd_bank", 64'(wbuf_rd_bank), 64'(0));
    check("t1_busy_after", 64'(busy), 64'(0));
    check("t1_ovf", 64'(start_ovf), 64'(0));

    // back-to-back loads from bank 0, in_ch=8, base 0
    do_reset();
    in_ch       = 8'd8;
    weight_base = '0;
    snap();
    do_start(8'd0);
    wait_done(100);
    check_load("t2a", 18'h000, 9, 1'b0);
    check("t2a_rd_bank", 64'(wbuf_rd_bank), 64'(0));
    snap();
    do_start(8'd1);
    check("t2_b2b_start", 64'(t0), 64'(done_cyc + 1));
    wait_done(100);
    check_load("t2b", 18'h009, 9, 1'b1);
    check("t2b_rd_bank", 64'(wbuf_rd_bank), 64'(1));
    check("t2b_ovf", 64'(start_ovf), 64'(0));

    // grant low every other cycle, in_ch=8, och 0, base 0x40
    in_ch       = 8'd8;
    weight_base = 18'h40;
    sram_gnt    = 1'b0;
    gnt_mode    = 1'b1;
    snap();
    do_start(8'd0);
    wait_done(200);
    gnt_mode = 1'b0;
    sram_gnt = 1'b1;
    check_load("t3", 18'h040, 9, 1'b0);
    check("t3_hold_seen", 64'(hold_cnt - h0 > 0), 64'(1));
    check("t3_hold_bad", 64'(hold_bad - hb0), 64'(0));
    if (wr_cyc.size() >= w0 + 9)
      check("t3_done_after_drain", 64'(done_cyc), 64'(wr_cyc[w0+8] + 1));

    // starts mid-load and in the DONE cycle are dropped
    do_reset();
    in_ch       = 8'd8;
    weight_base = '0;
    snap();
    do_start(8'd0);
    while (cyc < t0 + 5) step();
    weight_start = 1'b1;
    step();
    weight_start = 1'b0;
    check("t4_ovf_mid", 64'(start_ovf), 64'(1));
    while (cyc < t0 + 12) step();
    check("t4_in_done", 64'(weight_done), 64'(1));
    weight_start = 1'b1;
    step();
    weight_start = 1'b0;
    repeat (20) step();
    check("t4_done_cnt", 64'(done_cnt - d0), 64'(1));
    check("t4_done_cyc", 64'(done_cyc), 64'(t0 + 12));
    check("t4_rd_count", 64'(rd_addr.size() - r0), 64'(9));
    check("t4_ovf", 64'(start_ovf), 64'(1));
    check("t4_busy", 64'(busy), 64'(0));

    // in_ch=0: no reads, no writes, done in T+2, bank still toggles
    do_reset();
    in_ch = 8'd0;
    snap();
    do_start(8'd3);
    wait_done(20);
    check("t5_done_cyc", 64'(done_cyc), 64'(t0 + 2));
    check("t5_rd_count", 64'(rd_addr.size() - r0), 64'(0));
    check("t5_wr_count", 64'(wr_addr.size() - w0), 64'(0));
    check("t5_rd_bank_a", 64'(wbuf_rd_bank), 64'(0));
    snap();
    do_start(8'd3);
    wait_done(20);
    check("t5_rd_bank_b", 64'(wbuf_rd_bank), 64'(1));
    check("t5_wr_bank_now", 64'(wbuf_bank), 64'(0));

    // reset during READ abandons the load
    do_reset();
    in_ch       = 8'd16;
    weight_base = 18'h100;
    snap();
    do_start(8'd0);
    while (cyc < t0 + 6) step();
    check("t6_in_read", 64'(sram_rd_en), 64'(1));
    rst_n = 1'b0;
    #1;
    check("t6_rst_rd_en", 64'(sram_rd_en), 64'(0));
    check("t6_rst_addr", 64'(sram_addr), 64'(0));
    check("t6_rst_we", 64'(wbuf_we), 64'(0));
    check("t6_rst_busy", 64'(busy), 64'(0));
    check("t6_rst_done", 64'(weight_done), 64'(0));
    check("t6_rst_bank", 64'(wbuf_bank), 64'(0));
    check("t6_rst_rd_bank", 64'(wbuf_rd_bank), 64'(0));
    step();
    step();
    rst_n = 1'b1;
    repeat (5) step();
    check("t6_no_done", 64'(done_cnt - d0), 64'(0));
    snap();
    do_start(8'd0);
    wait_done(100);
    check_load("t6", 18'h100, 18, 1'b0);
    check("t6_done_cyc", 64'(done_cyc), 64'(t0 + 21));
    check("t6_rd_bank", 64'(wbuf_rd_bank), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/weight_loader.md
Name: weight_loader

Overview:
- Fetches the 3x3 weight set for one output channel from the weight SRAM into a ping-pong weight buffer.
- Sits directly downstream of the accelerator main FSM. It consumes weight_start and weight_och_cnt and returns weight_done.
- The conv engine reads the bank that completed last while the other bank is being filled.

Parameters:
- ADDR_W, 18, SRAM word address width.
- DATA_W, 64, SRAM word width: LANES int8 weights, one tap, LANES consecutive input channels.
- LANES, 8, input channels packed per SRAM word.
- WB_AW, 9, weight-buffer word address width (max 32 groups x 9 taps = 288 words).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_ch  in  8  input channel count (register setting)
- weight_base  in  ADDR_W  SRAM base address of the weight region
- weight_start  in  1  one-cycle load request
- weight_och_cnt  in  8  output channel to load, sampled with weight_start
- weight_done  out  1  one-cycle pulse when the load completes
- busy  out  1  high from the accepted start until weight_done
- start_ovf  out  1  sticky flag: a start arrived while busy
- sram_rd_en  out  1  read request
- sram_addr  out  ADDR_W  read address
- sram_gnt  in  1  read accepted this cycle when high together with sram_rd_en
- sram_rdata  in  DATA_W  read data, valid exactly 1 cycle after an accepted read
- wbuf_we  out  1  weight buffer write enable
- wbuf_bank  out  1  bank being written
- wbuf_addr  out  WB_AW  word index within the bank
- wbuf_wdata  out  DATA_W  write data (sram_rdata passthrough)
- wbuf_rd_bank  out  1  bank holding the last completed load

Behaviour:
- Reset (async, rst_n low): state IDLE. All outputs 0; bank pointer 0; counters 0; start_ovf 0. Asserting reset mid-load abandons the load: no weight_done, and the bank does not toggle.
- Derived values:
  - groups = ceil(in_ch/LANES) = (in_ch+LANES-1)>>log2(LANES).
  - words N = groups*9.
  - base = weight_base + weight_och_cnt*N, truncated to ADDR_W.
  - All of these are computed in CALC and registered; in_ch is sampled there.
- FSM states: IDLE, CALC, READ, DRAIN, DONE.
  - IDLE: on weight_start, latch och and go to CALC; busy=1 from the next cycle.
  - CALC: register base and N. If N==0 go to DONE; else go to READ.
  - READ: sram_rd_en=1, sram_addr = base + issue_cnt. issue_cnt increments only on rd_en&gnt. Stay in READ while gnt is low (address is held stable). On the accepted read with issue_cnt==N-1, go to DRAIN.
  - DRAIN: wait one cycle for the last data, then go to DONE.
  - DONE: weight_done=1 for one cycle; bank toggles; wbuf_rd_bank takes the just-written bank; go to IDLE; busy drops.
- Write path:
  - rvalid = registered (rd_en&gnt).
  - wbuf_we = rvalid; wbuf_addr = wr_cnt; wbuf_wdata = sram_rdata; wbuf_bank = current bank.
  - wr_cnt increments per write and is cleared in CALC.
  - Word order is tap-major: addr = tap*groups + group, matching SRAM order.
- Latency with gnt held high, start accepted in cycle T:
  - reads issue in T+2 .. T+N+1;
  - writes land in T+3 .. T+N+2;
  - weight_done is asserted in T+N+3.
- weight_start while busy (including in DONE): ignored and start_ovf set. start_ovf clears only on reset.
- weight_start in the same cycle weight_done is high: also ignored (DONE counts as busy).
- Arithmetic: the address sum wraps modulo 2^ADDR_W. in_ch>255 is not possible; the max N of 288 fits in WB_AW.

Decomposition:
- Shared package (acc_pkg):
  - state encodings;
  - KTAPS=9;
  - LANES;
  - ADDR_W/DATA_W defaults.
- One natural sub-module, wl_addr_gen: CALC multiply/add plus issue counter producing sram_addr and the last-issue flag.
- The FSM and write path stay in the top module.

Test Plan:
- in_ch=16, och=2, weight_base=0x100, gnt=1:
  - N=18, reads at 0x124..0x135;
  - 18 writes to bank 0, addr 0..17;
  - weight_done in T+21;
  - wbuf_rd_bank=0 afterwards.
- Two back-to-back loads (och 0 then 1, in_ch=8): second load writes bank 1, reads 0x009..0x011; wbuf_rd_bank=1 after the second done.
- in_ch=8, gnt low in every other cycle:
  - sram_addr holds while gnt=0;
  - exactly 9 writes with contiguous wbuf_addr 0..8;
  - done 1 cycle after DRAIN.
- weight_start pulsed mid-load and again in the DONE cycle: no extra load, start_ovf=1, single weight_done.
- in_ch=0: no sram_rd_en and no writes; weight_done in T+2; bank toggles.
- rst_n low during READ (in_ch=16): all outputs 0 immediately; no weight_done; bank stays 0; a new start after release performs a normal load into bank 0.
